dibit_symbol_transmitter: RTL and testbench
===========================================

Name: dibit_symbol_transmitter

Overview:
- Transmit side of the 2-bit symbol link. Downstream receivers decode each symbol with a case-style branch on {00,01,10,11}.
- Accepts parallel words over a valid/ready handshake and serializes each into 2-bit symbols, MSB-pair first, over a second valid/ready handshake.
- Provides an output-enable so the board-level driver floats the symbol lines (2'bzz) whenever no symbol is offered.
- Receivers classify 2'bzz as invalid, so the link is never driven with a stale symbol.

Parameters:
- DATA_WIDTH, 8, input word width; must be even and >= 2 (elaboration error otherwise).
- SYMS, DATA_WIDTH/2, symbols per word (localparam, not overridable).
- CNT_WIDTH, 16, width of the words-sent counter.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_WIDTH  word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- sym_out  output  2  current symbol.
- sym_valid  output  1  sym_out is valid.
- sym_ready  input  1  downstream consumes sym_out this cycle.
- sym_oe  output  1  pad output-enable; equals sym_valid.
- busy  output  1  a word is in progress (state SEND).
- words_sent  output  CNT_WIDTH  count of fully transmitted words; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (reset=1 at clk edge):
  - state=IDLE, shift register=0, symbol index=0, sym_valid=0, sym_out=2'b00, sym_oe=0, busy=0, words_sent=0.
  - in_ready is forced 0 while reset is high.
  - Reset mid-word abandons the word. No partial completion is counted, and the next symbol offered after reset is the MSB pair of a newly accepted word.
- FSM states:
  - IDLE: sym_valid=0, in_ready=1. If in_valid, load in_data into the shift register, set index=0, go to SEND. The first symbol appears on sym_out with sym_valid=1 the next cycle, so accept-to-first-symbol latency is 1 cycle.
  - SEND: sym_out=shift_reg[DATA_WIDTH-1:DATA_WIDTH-2], sym_valid=1.
    - Symbol transfer occurs when sym_valid and sym_ready are both 1. On transfer: shift left by 2 and index+1.
    - sym_out and sym_valid hold stable while sym_ready=0. There is no timeout.
- Last symbol (index==SYMS-1):
  - in_ready = sym_ready (combinational); words_sent increments on the transfer.
  - If in_valid is also 1, the new word loads in the same cycle and SEND continues. This gives back-to-back words with no bubble: sym_valid stays 1 and the next cycle shows the new word's MSB pair.
  - If in_valid is 0, go to IDLE and sym_valid drops to 0 the next cycle.
- in_ready = (state==IDLE) | (state==SEND & index==SYMS-1 & sym_ready); 0 otherwise.
- in_data is sampled only on an in_valid & in_ready cycle. Changes to in_data at other times have no effect.
- Symbol order for in_data = d: d[DW-1:DW-2], d[DW-3:DW-4], ..., d[1:0].
- busy = (state==SEND).
- In IDLE, sym_out is driven 2'b00, but sym_oe=0 so the pad reads 2'bzz.
- words_sent at all-ones wraps to 0 on the next completion.
- Throughput: with sym_ready held at 1, one word per SYMS cycles sustained.

Test Plan:
- Reset then single word 8'hB4, sym_ready=1 -> symbols 10,11,01,00 on 4 consecutive cycles starting 1 cycle after accept; sym_valid low afterwards; words_sent=1; busy low.
- Back-to-back 8'h1B then 8'hE4, in_valid held, sym_ready=1 -> 8 consecutive valid symbols 00,01,10,11,11,10,01,00 with no gap; in_ready high only on the accept cycle and the last-symbol cycles; words_sent=2.
- Backpressure on 8'h6C: sym_ready=0 for 3 cycles while the second symbol (10) is offered -> sym_out holds 10 and sym_valid holds 1; after sym_ready returns, the sequence resumes 11,00; in_ready stays 0 throughout the stall.
- Reset asserted during the third symbol of 8'hFF, then word 8'h00 -> after reset sym_valid=0, words_sent=0; next output is 00,00,00,00 with no leftover 11 symbols.
- Idle behaviour: no in_valid for 10 cycles -> sym_valid=0, sym_oe=0, pad model reads 2'bzz, in_ready=1.
- Counter wrap with CNT_WIDTH=2: send 5 words -> words_sent goes 1,2,3,0,1.

Source files
------------

// File: rtl/dibit_symbol_transmitter.sv
// Serializes DATA_WIDTH-bit words into 2-bit symbols, MSB pair first.
// Both sides use valid/ready handshakes, and sym_oe lets the pad float when no symbol is offered.
module dibit_symbol_transmitter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [1:0]            sym_out,
  output logic                  sym_valid,
  input  logic                  sym_ready,
  output logic                  sym_oe,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  localparam int unsigned SYMS  = DATA_WIDTH / 2;
  localparam int unsigned IDX_W = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS - 1);

  if ((DATA_WIDTH < 2) || ((DATA_WIDTH % 2) != 0)) begin : g_bad_width
    $error("DATA_WIDTH must be even and >= 2");
  end

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  sym_valid_q;
  logic [CNT_WIDTH-1:0]  words_sent_q;

  logic last_sym;
  logic xfer;
  logic accept;

  assign last_sym = (state_q == StSend) && (idx_q == LAST_IDX);
  assign xfer     = sym_valid_q && sym_ready;
  // A new word can be taken while the final symbol of the current word is consumed.
  assign in_ready = !reset && ((state_q == StIdle) || (last_sym && sym_ready));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      idx_q        <= '0;
      sym_valid_q  <= 1'b0;
      words_sent_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shift_q     <= in_data;
            idx_q       <= '0;
            sym_valid_q <= 1'b1;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (xfer) begin
            if (last_sym) begin
              words_sent_q <= words_sent_q + CNT_WIDTH'(1);
              idx_q        <= '0;
              if (accept) begin
                shift_q <= in_data;
              end else begin
                shift_q     <= '0;
                sym_valid_q <= 1'b0;
                state_q     <= StIdle;
              end
            end else begin
              shift_q <= shift_q << 2;
              idx_q   <= idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          sym_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sym_out    = sym_valid_q ? shift_q[DATA_WIDTH-1 -: 2] : 2'b00;
  assign sym_valid  = sym_valid_q;
  assign sym_oe     = sym_valid_q;
  assign busy       = (state_q == StSend);
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_dibit_symbol_transmitter.sv
// Directed and random checks of dibit_symbol_transmitter against a word-level model
// that tracks the current word and its remaining symbol count.
module tb_dibit_symbol_transmitter;

  localparam int unsigned DW   = 8;
  localparam int unsigned CW   = 2;
  localparam int unsigned SYMS = DW / 2;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    sym_out;
  logic          sym_valid;
  logic          sym_ready;
  logic          sym_oe;
  logic          busy;
  logic [CW-1:0] words_sent;
  logic [1:0]    pad;

  dibit_symbol_transmitter #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_oe    (sym_oe),
    .busy      (busy),
    .words_sent(words_sent)
  );

  assign pad = sym_oe ? sym_out : 2'bzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: one word in flight, 'left' symbols of it still to go.
  logic [DW-1:0] m_word  = '0;
  int            m_left  = 0;
  int            m_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [DW-1:0] d, input logic r);
    logic       e_valid;
    logic       e_ready;
    logic [1:0] e_sym;
    logic [1:0] e_pad;
    int         k;
    reset     = rst;
    in_valid  = v;
    in_data   = d;
    sym_ready = r;
    @(negedge clk);
    e_valid = (m_left > 0);
    e_ready = !rst && ((m_left == 0) || ((m_left == 1) && r));
    k       = SYMS - m_left;
    e_sym   = e_valid ? 2'((m_word >> (DW - 2 - 2 * k)) & 3) : 2'b00;
    e_pad   = e_valid ? e_sym : 2'bzz;
    chk("in_ready", 32'(in_ready), 32'(e_ready));
    chk("sym_valid", 32'(sym_valid), 32'(e_valid));
    chk("sym_oe", 32'(sym_oe), 32'(e_valid));
    chk("busy", 32'(busy), 32'(e_valid));
    chk("sym_out", 32'(sym_out), 32'(e_sym));
    chk("pad", {30'd0, pad}, {30'd0, e_pad});
    chk("words_sent", 32'(words_sent), 32'(m_count % (1 << CW)));
    if (rst) begin
      m_left  = 0;
      m_word  = '0;
      m_count = 0;
    end else begin
      if (e_valid && r) begin
        m_left--;
        if (m_left == 0) m_count++;
      end
      if (v && e_ready) begin
        m_word = d;
        m_left = SYMS;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int wrap_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    sym_ready = 1'b0;
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);

    // Single word: 10,11,01,00
    step(0, 1, 8'hB4, 1);
    repeat (5) step(0, 0, 8'h00, 1);

    // Back-to-back words with in_valid held
    step(0, 1, 8'h1B, 1);
    repeat (4) step(0, 1, 8'hE4, 1);
    repeat (5) step(0, 0, 8'h00, 1);

    // Backpressure while second symbol is offered
    step(0, 1, 8'h6C, 1);
    step(0, 0, 8'h00, 1);
    repeat (3) step(0, 1, 8'hAA, 0);
    repeat (4) step(0, 0, 8'h00, 1);

    // Reset during third symbol abandons the word
    step(0, 1, 8'hFF, 1);
    repeat (2) step(0, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h00, 1);
    repeat (5) step(0, 0, 8'h00, 1);

    // Idle
    repeat (10) step(0, 0, DW'($urandom), 1);

    // Counter wrap at CW=2
    step(1, 0, 8'h00, 0);
    for (int w = 0; w < 5; w++) begin
      step(0, 1, DW'($urandom), 1);
      repeat (4) step(0, 0, 8'h00, 1);
      chk("wrap", 32'(words_sent), 32'(wrap_exp[w]));
    end

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), DW'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
